// File: rtl/adder_sequencer_pkg.sv
// Shared definitions for the RSA adder sequencer and the sync adder it drives.
package adder_sequencer_pkg;

  localparam int RSA_DW_DEF = 16;

  localparam logic [1:0] MODE_NONE      = 2'b00;
  localparam logic [1:0] MODE_ADD       = 2'b01;
  localparam logic [1:0] MODE_C_MINUS_M = 2'b10;
  localparam logic [1:0] MODE_M_MINUS_C = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth valid/data delay line; each data stage only loads behind a valid
// bit, so the output holds the last valid element across gaps.
module valid_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= i_vld;
      if (i_vld) dat_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign o_vld  = vld_pipe[DEPTH-1];
  assign o_data = dat_pipe[DEPTH-1];

endmodule

// File: rtl/adder_sequencer.sv
// Streams M operands against a BRAM-resident C vector through the sync adder
// and writes the registered sums back to the result BRAM.
module adder_sequencer
  import adder_sequencer_pkg::*;
#(
  parameter int RSA_DW   = RSA_DW_DEF,
  parameter int ADDR_W   = 10,
  parameter int LEN_W    = 8,
  parameter int C_RD_LAT = 2
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [1:0]        op_mode,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_c_addr,
  input  logic [ADDR_W-1:0] base_w_addr,
  output logic              busy,
  output logic              done,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [RSA_DW-1:0] m_data,
  output logic              c_rd_en,
  output logic [ADDR_W-1:0] c_rd_addr,
  input  logic [RSA_DW-1:0] c_rd_data,
  output logic [1:0]        mode,
  output logic [RSA_DW-1:0] adder_M,
  output logic [RSA_DW-1:0] adder_C,
  input  logic [RSA_DW-1:0] sum,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [RSA_DW-1:0] w_data
);

  seq_state_e        r_state;
  logic [1:0]        r_mode;
  logic [LEN_W-1:0]  r_len, r_rd_idx, r_wr_idx;
  logic [ADDR_W-1:0] r_base_c, r_base_w;
  logic              r_busy, r_done, r_m_ready, r_wvld;

  logic              w_hs, w_dl_vld;
  logic [RSA_DW-1:0] w_dl_data;
  logic [LEN_W+1:0]  w_wr_sched;

  assign w_hs = m_valid & r_m_ready;

  valid_delay_line #(.DEPTH(C_RD_LAT), .WIDTH(RSA_DW)) u_dly (
    .clk    (clk),
    .rst_n  (sys_rst_n),
    .i_vld  (w_hs),
    .i_data (m_data),
    .o_vld  (w_dl_vld),
    .o_data (w_dl_data)
  );

  // Writes done + write issuing now + write issuing next cycle: lets DONE land
  // on the cycle of the last write so done pulses right after it.
  assign w_wr_sched = {2'b00, r_wr_idx}
                    + {{(LEN_W+1){1'b0}}, r_wvld}
                    + {{(LEN_W+1){1'b0}}, w_dl_vld};

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_NONE;
      r_len     <= '0;
      r_rd_idx  <= '0;
      r_wr_idx  <= '0;
      r_base_c  <= '0;
      r_base_w  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_m_ready <= 1'b0;
      r_wvld    <= 1'b0;
    end else begin
      r_wvld <= w_dl_vld;
      if (w_hs)   r_rd_idx <= r_rd_idx + LEN_W'(1);
      if (r_wvld) r_wr_idx <= r_wr_idx + LEN_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (r_done) begin
            r_done <= 1'b0;
            r_busy <= 1'b0;
          end else if (start) begin
            r_mode   <= op_mode;
            r_len    <= len;
            r_base_c <= base_c_addr;
            r_base_w <= base_w_addr;
            r_rd_idx <= '0;
            r_wr_idx <= '0;
            r_busy   <= 1'b1;
            if (len != '0) begin
              r_state   <= ST_RUN;
              r_m_ready <= 1'b1;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (w_hs && (r_rd_idx == r_len - LEN_W'(1))) begin
            r_m_ready <= 1'b0;
            r_state   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_wr_sched == {2'b00, r_len}) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign m_ready   = r_m_ready;
  assign c_rd_en   = w_hs;
  assign c_rd_addr = r_base_c + ADDR_W'(r_rd_idx);
  assign mode      = r_mode;
  assign adder_M   = w_dl_data;
  assign adder_C   = c_rd_data;
  assign w_en      = r_wvld;
  assign w_addr    = r_base_w + ADDR_W'(r_wr_idx);
  assign w_data    = sum;

endmodule

// File: tb/tb_adder_sequencer.sv
// Scoreboard bench: BRAM and sync adder models around the sequencer.
module tb_adder_sequencer;
  import adder_sequencer_pkg::*;

  localparam int DW = 16, AW = 10, LW = 8, LAT = 2;

  logic          clk = 1'b0, sys_rst_n = 1'b0, start = 1'b0;
  logic [1:0]    op_mode = 2'b00;
  logic [LW-1:0] len = '0;
  logic [AW-1:0] base_c_addr = '0, base_w_addr = '0;
  logic          busy, done, m_valid = 1'b0, m_ready, c_rd_en, w_en;
  logic [DW-1:0] m_data = '0, c_rd_data, adder_M, adder_C, w_data;
  logic [DW-1:0] sum = '0;
  logic [AW-1:0] c_rd_addr, w_addr;
  logic [1:0]    mode;

  always #5 clk = ~clk;

  adder_sequencer #(.RSA_DW(DW), .ADDR_W(AW), .LEN_W(LW), .C_RD_LAT(LAT)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .start(start), .op_mode(op_mode), .len(len),
    .base_c_addr(base_c_addr), .base_w_addr(base_w_addr), .busy(busy), .done(done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .c_rd_en(c_rd_en),
    .c_rd_addr(c_rd_addr), .c_rd_data(c_rd_data), .mode(mode), .adder_M(adder_M),
    .adder_C(adder_C), .sum(sum), .w_en(w_en), .w_addr(w_addr), .w_data(w_data)
  );

  // C BRAM with two-cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_p1 = '0, rd_p2 = '0;
  always @(posedge clk) begin
    if (c_rd_en) rd_p1 <= mem[c_rd_addr];
    rd_p2 <= rd_p1;
  end
  assign c_rd_data = rd_p2;

  // sync adder: registered, one cycle
  always @(posedge clk) begin
    case (mode)
      MODE_NONE:      sum <= adder_C;
      MODE_ADD:       sum <= adder_C + adder_M;
      MODE_C_MINUS_M: sum <= adder_C - adder_M;
      default:        sum <= adder_M - adder_C;
    endcase
  end

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t exp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0;
  int hs_n = 0, wr_n = 0, done_n = 0, crd_n = 0, mrdy_n = 0;
  int hs0 = 0, first_wr = 0, last_wr = 0, done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // monitor: logs events and checks every write against the scoreboard
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      if (hs_n == 0) hs0 = cyc;
      hs_n++;
    end
    if (c_rd_en) crd_n++;
    if (m_ready) mrdy_n++;
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (w_en) begin
      if (wr_n == 0) first_wr = cyc;
      last_wr = cyc;
      wr_n++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h expected=none", w_addr, w_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(w_addr), 32'(e.a));
        chk("wr_data", 32'(w_data), 32'(e.d));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hs_n = 0; wr_n = 0; done_n = 0; crd_n = 0; mrdy_n = 0;
  endtask

  task automatic go(input logic [1:0] m, input int l, input int bc, input int bw);
    op_mode = m; len = LW'(l); base_c_addr = AW'(bc); base_w_addr = AW'(bw);
    start = 1'b1;
    @(negedge clk) start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] expd,
                      input int a, input int gap, input bit push);
    int n = 0;
    m_valid = 1'b1; m_data = d;
    @(negedge clk);
    while (!m_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready) begin
      checks++;
      failures++;
      $display("FAIL m_ready_timeout actual=0 expected=1");
      m_valid = 1'b0;
    end else begin
      if (push) exp_q.push_back('{AW'(a), expd});
      @(posedge clk); #1;
      m_valid = 1'b0;
      if (gap > 0) tick(gap);
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done_n == 0 && n < 100) begin
      tick();
      n++;
    end
    tick(2);
    chk(nm, 32'(done_n), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem['h10] = 16'd1; mem['h11] = 16'd2; mem['h12] = 16'd3; mem['h13] = 16'd4;
    mem['h20] = 16'd5; mem['h21] = 16'hFFFD;
    mem['h28] = 16'h7FFF; mem['h29] = 16'h1234;
    mem['h30] = 16'd100; mem['h31] = 16'd200; mem['h32] = 16'd300;

    tick(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_m_ready", 32'(m_ready), 0);
    chk("rst_c_rd_en", 32'(c_rd_en), 0);
    chk("rst_w_en", 32'(w_en), 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_adder_M", 32'(adder_M), 0);
    chk("rst_c_rd_addr", 32'(c_rd_addr), 0);
    chk("rst_w_addr", 32'(w_addr), 0);
    sys_rst_n = 1'b1;
    tick(2);

    // ADD len=4, continuous stream
    clr();
    go(MODE_ADD, 4, 'h10, 'h40);
    chk("t1_busy", 32'(busy), 1);
    send(16'd10, 16'd11, 'h40, 0, 1);
    send(16'd20, 16'd22, 'h41, 0, 1);
    send(16'd30, 16'd33, 'h42, 0, 1);
    send(16'd40, 16'd44, 'h43, 0, 1);
    wait_done("t1_done_n");
    chk("t1_nwr", 32'(wr_n), 4);
    chk("t1_first_lat", 32'(first_wr - hs0), 3);
    chk("t1_b2b", 32'(last_wr - first_wr), 3);
    chk("t1_done_lat", 32'(done_cyc - last_wr), 1);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_q_empty", 32'(exp_q.size()), 0);

    // C - M and M - C: C={5,-3}, M={7,-8}
    clr();
    go(MODE_C_MINUS_M, 2, 'h20, 'h50);
    send(16'd7, 16'hFFFE, 'h50, 0, 1);
    send(16'hFFF8, 16'd5, 'h51, 0, 1);
    wait_done("t2_done_n");
    clr();
    go(MODE_M_MINUS_C, 2, 'h20, 'h52);
    send(16'd7, 16'd2, 'h52, 0, 1);
    send(16'hFFF8, 16'hFFFB, 'h53, 0, 1);
    wait_done("t3_done_n");
    chk("t3_nwr", 32'(wr_n), 2);

    // ADD wrap-around and NONE pass-through
    clr();
    go(MODE_ADD, 1, 'h28, 'h60);
    send(16'd1, 16'h8000, 'h60, 0, 1);
    wait_done("t4_done_n");
    clr();
    go(MODE_NONE, 1, 'h29, 'h61);
    send(16'h5555, 16'h1234, 'h61, 0, 1);
    wait_done("t5_done_n");
    chk("t5_nwr", 32'(wr_n), 1);

    // len=0: done only, no traffic
    clr();
    go(MODE_ADD, 0, 'h10, 'h70);
    tick(4);
    chk("t6_done_n", 32'(done_n), 1);
    chk("t6_done_lat", 32'(done_cyc - start_cyc), 2);
    chk("t6_crd", 32'(crd_n), 0);
    chk("t6_mrdy", 32'(mrdy_n), 0);
    chk("t6_nwr", 32'(wr_n), 0);

    // gaps, write address wrap, stray start mid-run
    clr();
    go(MODE_ADD, 3, 'h30, 'h3FE);
    send(16'd1, 16'd101, 'h3FE, 2, 1);
    op_mode = MODE_NONE; len = LW'(5); base_w_addr = AW'('h100);
    start = 1'b1; tick(); start = 1'b0;
    send(16'd2, 16'd202, 'h3FF, 2, 1);
    send(16'd3, 16'd303, 'h000, 0, 1);
    wait_done("t7_done_n");
    tick(4);
    chk("t7_done_once", 32'(done_n), 1);
    chk("t7_nwr", 32'(wr_n), 3);
    chk("t7_busy_end", 32'(busy), 0);

    // reset after 2 of 4 elements: nothing more comes out
    clr();
    go(MODE_ADD, 4, 'h10, 'h80);
    send(16'd10, 16'd0, 0, 0, 0);
    send(16'd20, 16'd0, 0, 0, 0);
    sys_rst_n = 1'b0;
    #1;
    chk("t8_busy", 32'(busy), 0);
    chk("t8_m_ready", 32'(m_ready), 0);
    chk("t8_w_en", 32'(w_en), 0);
    chk("t8_adder_M", 32'(adder_M), 0);
    tick(5);
    sys_rst_n = 1'b1;
    tick(4);
    chk("t8_nwr", 32'(wr_n), 0);
    chk("t8_done_n", 32'(done_n), 0);
    chk("t8_busy_end", 32'(busy), 0);
    chk("t8_q_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
